tpu_seq_ctrl: RTL
=================

# tpu_seq_ctrl

Parametrised job sequencer for the systolic TPU datapath. It replaces free-running address counters and externally driven enables with one FSM. Per job, it processes `num_tiles` tiles; each tile pops one weight set from the weight FIFO, reloads the array, streams `num_rows` Unified Buffer rows, and writes every result row to the results SRAM at latency-matched addresses. It sits between the host control pins and the UB / weight FIFO / systolic array / results SRAM.

## Interface
- `ADDRESSSIZE`, 10, width of UB and results SRAM addresses
- `TILE_BW`, 8, width of the tile count and tile index
- `RESULT_LAT`, 17, cycles from `ub_rd_en` of a row to that row's `res_wr_en` (≥1)
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  job request; sampled only in IDLE
- `num_rows`  in  ADDRESSSIZE  rows per tile; sampled at start
- `num_tiles`  in  TILE_BW  tiles per job; sampled at start
- `ub_base`  in  ADDRESSSIZE  first UB address; sampled at start
- `res_base`  in  ADDRESSSIZE  first results address; sampled at start
- `fifo_empty`  in  1  weight FIFO empty flag
- `fifo_rd_en`  out  1  weight FIFO pop
- `we_rl`  out  1  systolic weight reload strobe
- `ub_rd_en`  out  1  UB read strobe
- `ub_addr`  out  ADDRESSSIZE  UB read address
- `res_wr_en`  out  1  results SRAM write enable
- `res_addr`  out  ADDRESSSIZE  results SRAM write address
- `tile_idx`  out  TILE_BW  index of the current tile
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at job end

## Operation
- States and transitions:
  - IDLE → WLOAD on `start` with `num_rows`≠0 and `num_tiles`≠0. If either is 0, `start` is ignored.
  - WLOAD: stays while `fifo_empty`. When not empty, asserts `fifo_rd_en` for one cycle and goes to RELOAD.
  - RELOAD: asserts `we_rl` for one cycle (FIFO data is valid this cycle), then goes to STREAM.
  - STREAM: asserts `ub_rd_en` for exactly `num_rows` consecutive cycles, then goes to DRAIN.
  - DRAIN: stays until the pending-write count is 0.
    - If more tiles remain: go to WLOAD and increment `tile_idx`.
    - Otherwise: go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- UB addressing: `ub_addr` = `ub_base` + `tile_idx`·`num_rows` + row, modulo 2^ADDRESSSIZE. Implement as a running counter, not a multiplier.
- Result path:
  - `ub_rd_en` feeds a RESULT_LAT-stage delay line. Its output is `res_wr_en`.
  - `res_addr` starts at `res_base` and increments after each write, continuous across tiles. It wraps modulo 2^ADDRESSSIZE.
- Pending-write counter: +1 on `ub_rd_en`, −1 on `res_wr_en`; both in the same cycle gives no change. Width is ADDRESSSIZE+1.
- Tiles do not overlap: the next weight pop waits for a full drain.
- `start` while `busy` is ignored. Parameters latched at start are stable for the whole job.
- Reset (including mid-job): state becomes IDLE, the delay line and all counters clear, and every output is 0 on the next edge. Writes still in flight are discarded.

## Timing
- Outputs decode from registers only; there is no combinational path from inputs to outputs.
- Reset values: `fifo_rd_en`, `we_rl`, `ub_rd_en`, `res_wr_en`, `busy`, `done` = 0; `ub_addr`, `res_addr`, `tile_idx` = 0.
- `start` accepted at edge 0 → WLOAD in cycle 1. With the FIFO non-empty:
  - `fifo_rd_en` in cycle 1.
  - `we_rl` in cycle 2.
  - `ub_rd_en` in cycles 3 … 2+R.
  - `res_wr_en` in cycles 3+L … 2+R+L.
  - Next tile's WLOAD, or DONE, in cycle 3+R+L.
- Single tile, no FIFO stall: `done` in cycle R+L+3 and `busy` falls in cycle R+L+4.
- Each FIFO-empty cycle in WLOAD adds one cycle of latency.

## Configuration
- `TPU_SEQ_PERF_EN` defined:
  - Adds output `cycle_count` (32 bits). It clears on accepted start and increments every cycle `busy`=1. It holds after DONE until the next start.
  - Adds output `stall_count` (32 bits), which counts WLOAD cycles with `fifo_empty`=1.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- Package `tpu_seq_pkg`: state enum (IDLE, WLOAD, RELOAD, STREAM, DRAIN, DONE) and the perf-counter width constant.
- Sub-module `tpu_seq_delay_line`: 1-bit shift register, parameter DEPTH=RESULT_LAT, synchronous reset to 0.

## Test plan
- R=4, T=1, L=17, bases 0/0, FIFO non-empty:
  - `fifo_rd_en`@1, `we_rl`@2, `ub_addr` 0..3 @3..6.
  - `res_addr` 0..3 @20..23, `done`@24.
- T=3, R=2, `ub_base`=100, `res_base`=50:
  - `ub_addr` 100..105, `res_addr` 50..55, `tile_idx` 0→1→2.
  - Exactly 3 `fifo_rd_en` and 3 `we_rl` pulses.
- FIFO empty for 5 cycles after start:
  - WLOAD holds with no `fifo_rd_en`.
  - `done` is 5 cycles later than the no-stall case.
  - With the macro, `stall_count`=5.
- `ub_base`=1022, R=4: `ub_addr` sequence 1022, 1023, 0, 1. `res_base`=1023 gives `res_addr` 1023, 0, 1, 2.
- `start` with `num_rows`=0, and `start` while `busy`: both are ignored, with no state change.
- `rst` asserted during STREAM: all outputs 0 next cycle, and no `res_wr_en` afterwards. A new job then runs with nominal timing.

Source files
------------

// File: rtl/tpu_seq_pkg.sv
// Shared types and constants for the TPU job sequencer.
package tpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WLOAD  = 3'd1,
        RELOAD = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } seq_state_e;

    localparam int PERF_W = 32;
    localparam logic [PERF_W-1:0] PERF_ONE = 32'd1;

endpackage

// File: rtl/tpu_seq_delay_line.sv
// 1-bit shift register that aligns UB read strobes with the results SRAM write strobe.
module tpu_seq_delay_line #(
    parameter int DEPTH = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 1) begin : g_single
            logic stage_r;

            // Single-stage delay.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_r <= 1'b0;
                end else begin
                    stage_r <= din;
                end
            end

            assign dout = stage_r;
        end else begin : g_multi
            logic [DEPTH-1:0] stage_r;

            // Multi-stage shift, oldest sample at the top bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_r <= {DEPTH{1'b0}};
                end else begin
                    stage_r <= {stage_r[DEPTH-2:0], din};
                end
            end

            assign dout = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/tpu_seq_ctrl.sv
// Job sequencer: weight pop, array reload, UB row streaming and latency-matched result writes.
// Optional perf counters (cycle_count, stall_count) are enabled by defining TPU_SEQ_PERF_EN.
module tpu_seq_ctrl
    import tpu_seq_pkg::*;
#(
    parameter int ADDRESSSIZE = 10,
    parameter int TILE_BW     = 8,
    parameter int RESULT_LAT  = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] num_rows,
    input  logic [TILE_BW-1:0]     num_tiles,
    input  logic [ADDRESSSIZE-1:0] ub_base,
    input  logic [ADDRESSSIZE-1:0] res_base,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    output logic                   we_rl,
    output logic                   ub_rd_en,
    output logic [ADDRESSSIZE-1:0] ub_addr,
    output logic                   res_wr_en,
    output logic [ADDRESSSIZE-1:0] res_addr,
    output logic [TILE_BW-1:0]     tile_idx,
    output logic                   busy,
`ifdef TPU_SEQ_PERF_EN
    output logic                   done,
    output logic [PERF_W-1:0]      cycle_count,
    output logic [PERF_W-1:0]      stall_count
`else
    output logic                   done
`endif
);

    localparam int PW = ADDRESSSIZE + 1;
    localparam logic [ADDRESSSIZE-1:0] ADDR_ZERO = {ADDRESSSIZE{1'b0}};
    localparam logic [ADDRESSSIZE-1:0] ADDR_ONE  = {{(ADDRESSSIZE-1){1'b0}}, 1'b1};
    localparam logic [TILE_BW-1:0]     TILE_ZERO = {TILE_BW{1'b0}};
    localparam logic [TILE_BW-1:0]     TILE_ONE  = {{(TILE_BW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]          PEND_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]          PEND_ONE  = {{(PW-1){1'b0}}, 1'b1};

    seq_state_e             state_r;
    logic [ADDRESSSIZE-1:0] num_rows_r;
    logic [ADDRESSSIZE-1:0] rows_left_r;
    logic [ADDRESSSIZE-1:0] ub_addr_r;
    logic [ADDRESSSIZE-1:0] res_addr_r;
    logic [TILE_BW-1:0]     num_tiles_r;
    logic [TILE_BW-1:0]     tile_idx_r;
    logic [PW-1:0]          pend_r;
    logic [PW-1:0]          pend_next_s;
    logic                   fifo_rd_en_r;
    logic                   we_rl_r;
    logic                   ub_rd_en_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   res_wr_en_s;
    logic                   accept_s;
    logic                   last_tile_s;

    assign accept_s    = (state_r == IDLE) && start &&
                         (num_rows != ADDR_ZERO) && (num_tiles != TILE_ZERO);
    assign last_tile_s = (tile_idx_r == (num_tiles_r - TILE_ONE));

    tpu_seq_delay_line #(
        .DEPTH (RESULT_LAT)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (ub_rd_en_r),
        .dout (res_wr_en_s)
    );

    // Next value of the in-flight write count; DRAIN exits on the edge it reaches zero.
    always_comb begin
        pend_next_s = pend_r;
        case ({ub_rd_en_r, res_wr_en_s})
            2'b10:   pend_next_s = pend_r + PEND_ONE;
            2'b01:   pend_next_s = pend_r - PEND_ONE;
            default: pend_next_s = pend_r;
        endcase
    end

    // Sequencer FSM with registered strobes and address counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            num_rows_r   <= ADDR_ZERO;
            rows_left_r  <= ADDR_ZERO;
            ub_addr_r    <= ADDR_ZERO;
            res_addr_r   <= ADDR_ZERO;
            num_tiles_r  <= TILE_ZERO;
            tile_idx_r   <= TILE_ZERO;
            pend_r       <= PEND_ZERO;
            fifo_rd_en_r <= 1'b0;
            we_rl_r      <= 1'b0;
            ub_rd_en_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            pend_r <= pend_next_s;
            // Both address counters advance once per strobe, so tiles chain without a multiplier.
            if (ub_rd_en_r) begin
                ub_addr_r <= ub_addr_r + ADDR_ONE;
            end
            if (res_wr_en_s) begin
                res_addr_r <= res_addr_r + ADDR_ONE;
            end

            case (state_r)
                IDLE: begin
                    fifo_rd_en_r <= 1'b0;
                    we_rl_r      <= 1'b0;
                    ub_rd_en_r   <= 1'b0;
                    done_r       <= 1'b0;
                    if (accept_s) begin
                        state_r      <= WLOAD;
                        busy_r       <= 1'b1;
                        num_rows_r   <= num_rows;
                        num_tiles_r  <= num_tiles;
                        ub_addr_r    <= ub_base;
                        res_addr_r   <= res_base;
                        tile_idx_r   <= TILE_ZERO;
                        fifo_rd_en_r <= ~fifo_empty;
                    end
                end
                WLOAD: begin
                    if (fifo_rd_en_r) begin
                        fifo_rd_en_r <= 1'b0;
                        we_rl_r      <= 1'b1;
                        state_r      <= RELOAD;
                    end else begin
                        fifo_rd_en_r <= ~fifo_empty;
                    end
                end
                RELOAD: begin
                    we_rl_r     <= 1'b0;
                    ub_rd_en_r  <= 1'b1;
                    rows_left_r <= num_rows_r;
                    state_r     <= STREAM;
                end
                STREAM: begin
                    rows_left_r <= rows_left_r - ADDR_ONE;
                    if (rows_left_r == ADDR_ONE) begin
                        ub_rd_en_r <= 1'b0;
                        state_r    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pend_next_s == PEND_ZERO) begin
                        if (last_tile_s) begin
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            tile_idx_r   <= tile_idx_r + TILE_ONE;
                            fifo_rd_en_r <= ~fifo_empty;
                            state_r      <= WLOAD;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    fifo_rd_en_r <= 1'b0;
                    we_rl_r      <= 1'b0;
                    ub_rd_en_r   <= 1'b0;
                    done_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en = fifo_rd_en_r;
    assign we_rl      = we_rl_r;
    assign ub_rd_en   = ub_rd_en_r;
    assign ub_addr    = ub_addr_r;
    assign res_wr_en  = res_wr_en_s;
    assign res_addr   = res_addr_r;
    assign tile_idx   = tile_idx_r;
    assign busy       = busy_r;
    assign done       = done_r;

`ifdef TPU_SEQ_PERF_EN
    logic [PERF_W-1:0] cycle_count_r;
    logic [PERF_W-1:0] stall_count_r;

    // Busy-cycle and weight-stall counters; a stall is a WLOAD cycle without a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_r <= {PERF_W{1'b0}};
            stall_count_r <= {PERF_W{1'b0}};
        end else if (accept_s) begin
            cycle_count_r <= {PERF_W{1'b0}};
            stall_count_r <= {PERF_W{1'b0}};
        end else begin
            if (busy_r) begin
                cycle_count_r <= cycle_count_r + PERF_ONE;
            end
            if ((state_r == WLOAD) && !fifo_rd_en_r) begin
                stall_count_r <= stall_count_r + PERF_ONE;
            end
        end
    end

    assign cycle_count = cycle_count_r;
    assign stall_count = stall_count_r;
`endif

endmodule
